// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 pipeline control blocks.
package riscv_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2,
    FAULT    = 2'd3
  } pipe_state_t;

  localparam logic [1:0] WB_LOAD = 2'b00;
  localparam int         WAIT_W  = 8;

endpackage

// File: rtl/wait_timer.sv
// Wait-cycle counter: clears on request, counts while enabled, flags the last allowed cycle.
module wait_timer
  import riscv_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(LIMIT - 1);

  logic [WAIT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + WAIT_W'(1);
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, MUL/DIV,
// memory wait states and taken branches into per-stage hold/bubble controls.
module pipe_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_addr_D,
  input  logic [4:0]       rs2_addr_D,
  input  logic [4:0]       rd_E,
  input  logic [1:0]       sel_wb_E,
  input  logic             reg_write_E,
  input  logic             md_op_E,
  input  logic             md_done,
  input  logic             branch_taken_E,
  input  logic             dmem_req_M,
  input  logic             dmem_ready,
  output logic             md_start,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output pipe_state_t      state_dbg
);

  pipe_state_t      state_q, state_d;
  logic             fault_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             mem_stall, lu, wait_en, expire;

  always_comb begin
    mem_stall = dmem_req_M & ~dmem_ready;
    lu = (sel_wb_E == WB_LOAD) & reg_write_E & (rd_E != 5'd0) &
         ((rs1_addr_D == rd_E) | (rs2_addr_D == rd_E));
    state_d  = state_q;
    wait_en  = 1'b0;
    md_start = 1'b0;
    stallF   = 1'b0;
    stallD   = 1'b0;
    stallE   = 1'b0;
    stallM   = 1'b0;
    flushD   = 1'b0;
    flushE   = 1'b0;
    flushM   = 1'b0;
    flushW   = 1'b0;
    if (state_q == FAULT) begin
      {stallF, stallD, stallE, stallM, flushW} = '1;
    end else if (mem_stall) begin
      // E is frozen, so a pending branch or MUL/DIV start is simply seen again later.
      {stallF, stallD, stallE, stallM, flushW} = '1;
      if (state_q == MEM_WAIT) begin
        wait_en = 1'b1;
        if (expire) state_d = FAULT;
      end else begin
        state_d = MEM_WAIT;
      end
    end else if (state_q == MD_WAIT && !md_done) begin
      {stallF, stallD, stallE, flushM} = '1;
      wait_en = 1'b1;
      if (expire) state_d = FAULT;
    end else if (state_q != MD_WAIT && md_op_E) begin
      {stallF, stallD, stallE, flushM} = '1;
      md_start = 1'b1;
      state_d  = MD_WAIT;
    end else begin
      state_d = RUN;
      if (branch_taken_E) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (lu) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  wait_timer #(
    .LIMIT(TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_d != state_q),
    .en_i     (wait_en),
    .expire_o (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      fault_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_q | (state_d == FAULT);
      if (stallF && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign fault     = fault_q;
  assign stall_cnt = stall_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with short timeout and narrow stall counter.
module tb_pipe_ctrl;
  import riscv_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  // control vector: {md_start, stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}
  localparam logic [8:0] C_IDLE = 9'b0_0000_0000;
  localparam logic [8:0] C_LU   = 9'b0_1100_0100;
  localparam logic [8:0] C_MDS  = 9'b1_1110_0010;
  localparam logic [8:0] C_MDW  = 9'b0_1110_0010;
  localparam logic [8:0] C_MEM  = 9'b0_1111_0001;
  localparam logic [8:0] C_BR   = 9'b0_0000_1100;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1_addr_D, rs2_addr_D, rd_E;
  logic [1:0]       sel_wb_E;
  logic             reg_write_E, md_op_E, md_done, branch_taken_E, dmem_req_M, dmem_ready;
  logic             md_start, stallF, stallD, stallE, stallM;
  logic             flushD, flushE, flushM, flushW, fault;
  logic [CNT_W-1:0] stall_cnt;
  pipe_state_t      state_dbg;
  logic [8:0]       ctl;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  pipe_ctrl #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rs1_addr_D    (rs1_addr_D),
    .rs2_addr_D    (rs2_addr_D),
    .rd_E          (rd_E),
    .sel_wb_E      (sel_wb_E),
    .reg_write_E   (reg_write_E),
    .md_op_E       (md_op_E),
    .md_done       (md_done),
    .branch_taken_E(branch_taken_E),
    .dmem_req_M    (dmem_req_M),
    .dmem_ready    (dmem_ready),
    .md_start      (md_start),
    .stallF        (stallF),
    .stallD        (stallD),
    .stallE        (stallE),
    .stallM        (stallM),
    .flushD        (flushD),
    .flushE        (flushE),
    .flushM        (flushM),
    .flushW        (flushW),
    .fault         (fault),
    .stall_cnt     (stall_cnt),
    .state_dbg     (state_dbg)
  );

  assign ctl = {md_start, stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    rs1_addr_D     = 5'd0;
    rs2_addr_D     = 5'd0;
    rd_E           = 5'd0;
    sel_wb_E       = 2'b01;
    reg_write_E    = 1'b0;
    md_op_E        = 1'b0;
    md_done        = 1'b0;
    branch_taken_E = 1'b0;
    dmem_req_M     = 1'b0;
    dmem_ready     = 1'b1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    sel_wb_E    = WB_LOAD;
    reg_write_E = 1'b1;
    rd_E        = rd;
    rs1_addr_D  = rs1;
    rs2_addr_D  = rs2;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    check("rst_ctl", 32'(ctl), 32'(C_IDLE));
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(RUN));
    @(negedge clk);
    rst = 1'b0;

    // load-use and its non-hazard variants
    set_load(5'd5, 5'd5, 5'd0);
    #1 check("lu_rs1", 32'(ctl), 32'(C_LU));
    step();
    check("lu_cnt1", 32'(stall_cnt), 32'd1);
    set_load(5'd0, 5'd0, 5'd0);
    #1 check("lu_rd0", 32'(ctl), 32'(C_IDLE));
    set_load(5'd7, 5'd1, 5'd7);
    #1 check("lu_rs2", 32'(ctl), 32'(C_LU));
    step();
    sel_wb_E = 2'b01;
    #1 check("lu_nonload", 32'(ctl), 32'(C_IDLE));
    step();
    check("lu_cnt2", 32'(stall_cnt), 32'd2);

    // branch overrides load-use
    set_load(5'd5, 5'd5, 5'd5);
    branch_taken_E = 1'b1;
    #1 check("br_over_lu", 32'(ctl), 32'(C_BR));
    step();
    check("br_cnt", 32'(stall_cnt), 32'd2);

    // md_done outside MD_WAIT
    idle();
    md_done = 1'b1;
    #1 check("stray_done", 32'(ctl), 32'(C_IDLE));
    step();
    check("stray_state", 32'(state_dbg), 32'(RUN));

    // MUL/DIV with 4-cycle latency
    do_reset();
    md_op_E = 1'b1;
    #1 check("md_start", 32'(ctl), 32'(C_MDS));
    step();
    check("md_state", 32'(state_dbg), 32'(MD_WAIT));
    for (int i = 0; i < 3; i++) begin
      #1 check("md_wait", 32'(ctl), 32'(C_MDW));
      step();
    end
    md_done = 1'b1;
    #1 check("md_release", 32'(ctl), 32'(C_IDLE));
    step();
    idle();
    check("md_end_state", 32'(state_dbg), 32'(RUN));
    check("md_cnt", 32'(stall_cnt), 32'd4);

    // memory wait hides a taken branch until ready
    do_reset();
    dmem_req_M     = 1'b1;
    dmem_ready     = 1'b0;
    branch_taken_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("mem_wait", 32'(ctl), 32'(C_MEM));
      step();
    end
    dmem_ready = 1'b1;
    #1 check("mem_ready_br", 32'(ctl), 32'(C_BR));
    step();
    check("mem_state", 32'(state_dbg), 32'(RUN));
    check("mem_cnt", 32'(stall_cnt), 32'd3);

    // memory wait defers a MUL/DIV start
    idle();
    dmem_req_M = 1'b1;
    dmem_ready = 1'b0;
    md_op_E    = 1'b1;
    #1 check("memmd_wait", 32'(ctl), 32'(C_MEM));
    step();
    check("memmd_state", 32'(state_dbg), 32'(MEM_WAIT));
    dmem_ready = 1'b1;
    #1 check("memmd_start", 32'(ctl), 32'(C_MDS));
    step();
    check("memmd_mdwait", 32'(state_dbg), 32'(MD_WAIT));
    dmem_req_M = 1'b0;
    md_done    = 1'b1;
    #1 check("memmd_done", 32'(ctl), 32'(C_IDLE));
    step();
    idle();
    check("memmd_run", 32'(state_dbg), 32'(RUN));
    check("memmd_cnt", 32'(stall_cnt), 32'd5);

    // timeout into FAULT, stall counter saturation, async reset
    do_reset();
    dmem_req_M = 1'b1;
    dmem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1 check("to_ctl", 32'(ctl), 32'(C_MEM));
      step();
      check("to_nofault", 32'(fault), 32'd0);
    end
    #1 check("to_last_ctl", 32'(ctl), 32'(C_MEM));
    step();
    check("to_fault", 32'(fault), 32'd1);
    check("to_state", 32'(state_dbg), 32'(FAULT));
    check("to_cnt9", 32'(stall_cnt), 32'd9);
    idle();
    md_op_E = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1 check("flt_ctl", 32'(ctl), 32'(C_MEM));
      step();
    end
    check("flt_sticky", 32'(fault), 32'd1);
    check("cnt_sat", 32'(stall_cnt), 32'd15);
    idle();
    #2 rst = 1'b1;
    #1;
    check("arst_fault", 32'(fault), 32'd0);
    check("arst_cnt", 32'(stall_cnt), 32'd0);
    check("arst_state", 32'(state_dbg), 32'(RUN));
    check("arst_ctl", 32'(ctl), 32'(C_IDLE));
    @(negedge clk);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
